echo_ranger: RTL and testbench
==============================

# echo_ranger

Ultrasonic ranging front end for the waiter platform's obstacle sensor. On a `start` request it drives a fixed-width trigger pulse, then measures the width of the returning echo pulse in whole microseconds. It reports the result with a one-cycle `valid` strobe, or flags a timeout. It is the measuring counterpart of the millisecond timer: instead of producing elapsed time, it converts an external pulse width into a time value for the distance/obstacle logic downstream.

## Interface
- `CLKS_PER_US`, 50, clock cycles per microsecond (50 MHz clock).
- `TRIG_US`, 10, trigger pulse width in µs.
- `TIMEOUT_US`, 30000, maximum wait or measure time in µs.
- `HOLDOFF_US`, 60, quiet time after each result before the next `start` is accepted.
- Derived constant `W = $clog2(TIMEOUT_US+1)`.

- `clk`  in  1  clock.
- `reset`  in  1  synchronous, active-high reset.
- `start`  in  1  request one measurement; sampled only in IDLE.
- `echo`  in  1  asynchronous echo line from sensor.
- `trigger`  out  1  trigger pulse to sensor, registered.
- `busy`  out  1  high in every state except IDLE.
- `valid`  out  1  one-cycle strobe: `echo_us`/`timeout` updated.
- `echo_us`  out  W  measured echo width in µs; held between strobes.
- `timeout`  out  1  last result was a timeout; held between strobes.

## Operation
- `echo` is passed through a 2-flop synchronizer (`echo_s`). All decisions use `echo_s`.
- The µs prescaler counts 0..CLKS_PER_US-1 and emits `us_tick` on its terminal count. It clears to 0 on every state change.
- The µs counter `us_cnt` (W bits) clears on every state change and increments on each `us_tick`.
- States:
  - **IDLE**
    - `start`=1 → TRIG.
  - **TRIG**
    - `trigger`=1.
    - When `us_cnt` reaches TRIG_US → WAIT_RISE.
  - **WAIT_RISE**
    - `echo_s`=1 → MEASURE.
    - If `us_cnt` reaches TIMEOUT_US first: `echo_us`←0, `timeout`←1, `valid` pulse → HOLDOFF.
  - **MEASURE**
    - `echo_s`=0: `echo_us`←`us_cnt`, `timeout`←0, `valid` pulse → HOLDOFF.
    - If `us_cnt` reaches TIMEOUT_US while `echo_s`=1: `echo_us`←TIMEOUT_US, `timeout`←1, `valid` pulse → HOLDOFF.
  - **HOLDOFF**
    - `us_cnt` reaches HOLDOFF_US → IDLE.
- `start` outside IDLE is ignored. It is not queued.
- `echo_s` already high on entry to WAIT_RISE (stuck-high or stale echo) is treated as a rise. It moves to MEASURE on the first WAIT_RISE cycle.
- Partial microseconds are truncated. `echo_us` never exceeds TIMEOUT_US; `us_cnt` saturates and does not wrap.
- `reset` mid-operation: next edge returns to IDLE, with `trigger`=0, `busy`=0, `valid`=0, `echo_us`=0, `timeout`=0, and prescaler, counter and synchronizer cleared.

## Timing
- Reset values: all outputs 0. State is IDLE.
- `start` high at edge N → `trigger` and `busy` high from edge N+1.
- `trigger` high for exactly TRIG_US·CLKS_PER_US cycles.
- Echo latency: `echo` to `echo_s` is 2 cycles. The `valid` edge is one cycle after `echo_s` falls.
- `valid` is registered and high for exactly one cycle. `echo_us`/`timeout` change only on that same edge.
- `busy` drops on the edge where HOLDOFF exits. `start` may be accepted on the following edge.
- Minimum `start` to `start` spacing: (TRIG_US + HOLDOFF_US)·CLKS_PER_US + 3 cycles.

## Structure
- `echo_ranger_pkg` holds:
  - the state enum `ranger_state_t` {IDLE, TRIG, WAIT_RISE, MEASURE, HOLDOFF};
  - the W-width helper function.
- Sub-module `us_prescaler` has inputs `clk`, `reset`, `clear` and output `us_tick`; parameter CLKS_PER_US.
- The synchronizer, FSM, `us_cnt` and result registers live in `echo_ranger`.

## Test plan
Bench parameters: CLKS_PER_US=50, TRIG_US=10, TIMEOUT_US=100, HOLDOFF_US=5.

1. Basic measurement.
   - Stimulus: `start` pulse; echo rises 20 µs after `trigger` falls and stays high 37.0 µs.
   - Required: `trigger` high 500 cycles. One `valid` with `echo_us`=37, `timeout`=0. `busy` low 250 cycles after `valid`.
2. Truncation.
   - Stimulus: echo high 12.98 µs (649 cycles).
   - Required: `echo_us`=12.
3. No echo.
   - Stimulus: `echo` held low.
   - Required: `valid` 100 µs after `trigger` falls, with `echo_us`=0, `timeout`=1.
4. Stuck-high echo.
   - Stimulus: `echo` held high.
   - Required: immediate MEASURE, then `valid` with `echo_us`=100, `timeout`=1. No wrap.
5. Start while busy.
   - Stimulus: `start` pulses during TRIG, MEASURE and HOLDOFF.
   - Required: exactly one `valid` per accepted `start`. `trigger` never reasserts early.
6. Reset mid-MEASURE.
   - Stimulus: `reset` asserted 5 µs into echo.
   - Required: next edge has all outputs 0. A following `start` produces a fresh, correct measurement.

Source files
------------

// File: rtl/echo_ranger_pkg.sv
// echo_ranger_pkg
// Shared types and helpers for the ultrasonic echo ranger.
//   ranger_state_t : measurement FSM states
//   cnt_width()    : bits needed to hold a count of 0..max_val
package echo_ranger_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        TRIG      = 3'd1,
        WAIT_RISE = 3'd2,
        MEASURE   = 3'd3,
        HOLDOFF   = 3'd4
    } ranger_state_t;

    // Width of a counter that must represent every value 0..max_val.
    function automatic int cnt_width(input int max_val);
        if (max_val < 2) begin
            return 1;
        end else begin
            return $clog2(max_val + 1);
        end
    endfunction

endpackage

// File: rtl/echo_ranger_us_prescaler.sv
// us_prescaler
// Divides the system clock down to a one-microsecond tick.
//   clk     in  : system clock
//   reset   in  : synchronous, active-high reset
//   clear   in  : restart the microsecond phase (asserted on FSM state changes)
//   us_tick out : high during the last clock of each microsecond
module us_prescaler
    import echo_ranger_pkg::*;
#(
    parameter int CLKS_PER_US = 50
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    output logic us_tick
);

    localparam int            PW   = cnt_width(CLKS_PER_US - 1);
    localparam logic [PW-1:0] TERM = PW'(CLKS_PER_US - 1);

    logic [PW-1:0] count_r;

    // Phase counter: 0..CLKS_PER_US-1, restarted by reset or clear.
    always_ff @(posedge clk) begin
        if (reset || clear || (count_r == TERM)) begin
            count_r <= '0;
        end else begin
            count_r <= count_r + PW'(1);
        end
    end

    assign us_tick = (count_r == TERM);

endmodule

// File: rtl/echo_ranger.sv
// echo_ranger
// Fires a trigger pulse at the ultrasonic sensor and measures the width of
// the returning echo in whole microseconds.
//   clk     in  : system clock
//   reset   in  : synchronous, active-high reset
//   start   in  : request one measurement (honoured only when idle)
//   echo    in  : asynchronous echo line from the sensor
//   trigger out : trigger pulse to the sensor
//   busy    out : high whenever a measurement or holdoff is in progress
//   valid   out : one-cycle strobe, echo_us/timeout updated on this edge
//   echo_us out : last measured echo width in us (held between strobes)
//   timeout out : last result was a timeout (held between strobes)
module echo_ranger
    import echo_ranger_pkg::*;
#(
    parameter  int CLKS_PER_US = 50,
    parameter  int TRIG_US     = 10,
    parameter  int TIMEOUT_US  = 30000,
    parameter  int HOLDOFF_US  = 60,
    localparam int W           = cnt_width(TIMEOUT_US)
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic         echo,
    output logic         trigger,
    output logic         busy,
    output logic         valid,
    output logic [W-1:0] echo_us,
    output logic         timeout
);

    localparam logic [W-1:0] TRIG_CNT    = W'(TRIG_US);
    localparam logic [W-1:0] TIMEOUT_CNT = W'(TIMEOUT_US);
    localparam logic [W-1:0] HOLDOFF_CNT = W'(HOLDOFF_US);

    ranger_state_t state_r;
    logic [1:0]    echo_sync_r;
    logic          echo_s;
    logic          us_tick_s;
    logic [W-1:0]  us_cnt_r;
    logic [W-1:0]  us_next_s;
    logic          advance_s;
    logic          trigger_r;
    logic          busy_r;
    logic          valid_r;
    logic [W-1:0]  echo_us_r;
    logic          timeout_r;

    // Two-flop synchronizer for the asynchronous echo line.
    always_ff @(posedge clk) begin
        if (reset) begin
            echo_sync_r <= 2'b00;
        end else begin
            echo_sync_r <= {echo_sync_r[0], echo};
        end
    end

    assign echo_s = echo_sync_r[1];

    us_prescaler #(
        .CLKS_PER_US(CLKS_PER_US)
    ) u_prescaler (
        .clk    (clk),
        .reset  (reset),
        .clear  (advance_s),
        .us_tick(us_tick_s)
    );

    // Microsecond count including the tick landing on this edge, so a full
    // final microsecond is credited; saturates instead of wrapping.
    always_comb begin
        us_next_s = us_cnt_r;
        if (us_tick_s && (us_cnt_r != TIMEOUT_CNT)) begin
            us_next_s = us_cnt_r + W'(1);
        end else begin
            us_next_s = us_cnt_r;
        end
    end

    // Transition condition of the current state; also restarts the prescaler.
    always_comb begin
        advance_s = 1'b0;
        case (state_r)
            IDLE:      advance_s = start;
            TRIG:      advance_s = (us_next_s == TRIG_CNT);
            WAIT_RISE: advance_s = echo_s || (us_next_s == TIMEOUT_CNT);
            MEASURE:   advance_s = !echo_s || (us_next_s == TIMEOUT_CNT);
            HOLDOFF:   advance_s = (us_next_s == HOLDOFF_CNT);
            default:   advance_s = 1'b1;
        endcase
    end

    // Measurement FSM, microsecond counter and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r   <= IDLE;
            us_cnt_r  <= '0;
            trigger_r <= 1'b0;
            busy_r    <= 1'b0;
            valid_r   <= 1'b0;
            echo_us_r <= '0;
            timeout_r <= 1'b0;
        end else begin
            valid_r  <= 1'b0;
            us_cnt_r <= advance_s ? '0 : us_next_s;
            case (state_r)
                IDLE: begin
                    if (start) begin
                        state_r   <= TRIG;
                        trigger_r <= 1'b1;
                        busy_r    <= 1'b1;
                    end
                end
                TRIG: begin
                    if (advance_s) begin
                        state_r   <= WAIT_RISE;
                        trigger_r <= 1'b0;
                    end
                end
                WAIT_RISE: begin
                    // An echo already high here (stale/stuck) counts as a rise.
                    if (echo_s) begin
                        state_r <= MEASURE;
                    end else if (advance_s) begin
                        echo_us_r <= '0;
                        timeout_r <= 1'b1;
                        valid_r   <= 1'b1;
                        state_r   <= HOLDOFF;
                    end
                end
                MEASURE: begin
                    if (!echo_s) begin
                        echo_us_r <= us_next_s;
                        timeout_r <= 1'b0;
                        valid_r   <= 1'b1;
                        state_r   <= HOLDOFF;
                    end else if (advance_s) begin
                        echo_us_r <= TIMEOUT_CNT;
                        timeout_r <= 1'b1;
                        valid_r   <= 1'b1;
                        state_r   <= HOLDOFF;
                    end
                end
                HOLDOFF: begin
                    if (advance_s) begin
                        state_r <= IDLE;
                        busy_r  <= 1'b0;
                    end
                end
                default: begin
                    state_r   <= IDLE;
                    trigger_r <= 1'b0;
                    busy_r    <= 1'b0;
                end
            endcase
        end
    end

    assign trigger = trigger_r;
    assign busy    = busy_r;
    assign valid   = valid_r;
    assign echo_us = echo_us_r;
    assign timeout = timeout_r;

endmodule

// File: tb/tb_echo_ranger.sv
// tb_echo_ranger
// Directed self-checking bench for echo_ranger with a shortened timeout
// (CLKS_PER_US=50, TRIG_US=10, TIMEOUT_US=100, HOLDOFF_US=5).
`timescale 1ns/1ps
module tb_echo_ranger;

    localparam int W = echo_ranger_pkg::cnt_width(100);

    logic         clk;
    logic         reset;
    logic         start;
    logic         echo;
    logic         trigger;
    logic         busy;
    logic         valid;
    logic [W-1:0] echo_us;
    logic         timeout;

    int n_checks;
    int n_fails;
    int valid_seen;
    int trig_rises;
    logic trig_prev;

    echo_ranger #(
        .CLKS_PER_US(50),
        .TRIG_US    (10),
        .TIMEOUT_US (100),
        .HOLDOFF_US (5)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .echo   (echo),
        .trigger(trigger),
        .busy   (busy),
        .valid  (valid),
        .echo_us(echo_us),
        .timeout(timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Event counters for valid strobes and trigger rising edges.
    always @(posedge clk) begin
        if (reset) begin
            trig_prev = 1'b0;
        end else begin
            if (valid === 1'b1) valid_seen++;
            if (trigger === 1'b1 && trig_prev !== 1'b1) trig_rises++;
            trig_prev = trigger;
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got simulation still running expected finished");
        $fatal(1, "watchdog expired");
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick(1);
        start = 1'b0;
    endtask

    task automatic check_outputs_zero(input string tag);
        check_eq({tag, "_trigger"}, 32'(trigger), 32'd0);
        check_eq({tag, "_busy"},    32'(busy),    32'd0);
        check_eq({tag, "_valid"},   32'(valid),   32'd0);
        check_eq({tag, "_echo_us"}, 32'(echo_us), 32'd0);
        check_eq({tag, "_timeout"}, 32'(timeout), 32'd0);
    endtask

    // Counts remaining trigger-high samples until it falls.
    task automatic wait_trigger_fall(input string tag, input int exp_cycles);
        int cnt = 0;
        while (trigger === 1'b1 && cnt < 2000) begin
            cnt++;
            tick(1);
        end
        check_eq({tag, "_trig_width"}, 32'(cnt), 32'(exp_cycles));
    endtask

    // Waits for the valid strobe, then checks result and that it is one cycle.
    task automatic expect_result(input string tag, input int exp_wait,
                                 input int exp_us, input logic exp_to);
        int waited = 0;
        while (valid !== 1'b1 && waited < 6000) begin
            tick(1);
            waited++;
        end
        check_eq({tag, "_valid_seen"}, 32'(valid),   32'd1);
        check_eq({tag, "_latency"},    32'(waited),  32'(exp_wait));
        check_eq({tag, "_echo_us"},    32'(echo_us), 32'(exp_us));
        check_eq({tag, "_timeout"},    32'(timeout), 32'(exp_to));
        tick(1);
        check_eq({tag, "_valid_1cyc"}, 32'(valid),   32'd0);
    endtask

    // Waits for busy to drop; exp_cycles < 0 skips the length check.
    task automatic wait_idle(input string tag, input int exp_cycles);
        int cnt = 0;
        while (busy === 1'b1 && cnt < 7000) begin
            cnt++;
            tick(1);
        end
        check_eq({tag, "_idle"}, 32'(busy), 32'd0);
        if (exp_cycles >= 0) check_eq({tag, "_busy_tail"}, 32'(cnt), 32'(exp_cycles));
    endtask

    initial begin
        int v0;
        int r0;
        n_checks   = 0;
        n_fails    = 0;
        valid_seen = 0;
        trig_rises = 0;
        trig_prev  = 1'b0;
        reset = 1'b1;
        start = 1'b0;
        echo  = 1'b0;
        tick(3);
        reset = 1'b0;
        check_outputs_zero("reset");
        tick(2);

        // 1: basic 37.0 us echo, rising 20 us after trigger falls.
        pulse_start();
        check_eq("basic_busy_start", 32'(busy), 32'd1);
        wait_trigger_fall("basic", 500);
        tick(999);
        echo = 1'b1;
        tick(1850);
        echo = 1'b0;
        // Echo drop to valid: 2 synchronizer flops + 1 registered strobe.
        expect_result("basic", 3, 37, 1'b0);
        // 250 holdoff cycles after valid, one already spent on the strobe check.
        wait_idle("basic", 249);
        tick(2);

        // 2: 649-cycle echo truncates to 12 us.
        pulse_start();
        wait_trigger_fall("trunc", 500);
        tick(100);
        echo = 1'b1;
        tick(649);
        echo = 1'b0;
        expect_result("trunc", 3, 12, 1'b0);
        wait_idle("trunc", -1);
        tick(2);

        // 3: no echo -> timeout 100 us (5000 cycles) after trigger falls.
        pulse_start();
        wait_trigger_fall("noecho", 500);
        expect_result("noecho", 5000, 0, 1'b1);
        wait_idle("noecho", -1);
        tick(2);

        // 5: start pulses during TRIG, MEASURE and HOLDOFF are ignored.
        v0 = valid_seen;
        r0 = trig_rises;
        pulse_start();
        tick(100);
        pulse_start();
        // 500 trigger cycles minus the 101 already elapsed.
        wait_trigger_fall("busystart", 399);
        tick(50);
        echo = 1'b1;
        tick(300);
        pulse_start();
        tick(200);
        echo = 1'b0;
        // Echo high 501 cycles -> 10 us.
        expect_result("busystart", 3, 10, 1'b0);
        tick(20);
        pulse_start();
        wait_idle("busystart", -1);
        tick(10);
        check_eq("busystart_valid_count", 32'(valid_seen - v0), 32'd1);
        check_eq("busystart_trig_rises",  32'(trig_rises - r0), 32'd1);
        check_eq("busystart_trig_low",    32'(trigger), 32'd0);

        // 4: stuck-high echo -> MEASURE one cycle after WAIT_RISE, saturate at 100.
        echo = 1'b1;
        tick(5);
        pulse_start();
        wait_trigger_fall("stuck", 500);
        expect_result("stuck", 5001, 100, 1'b1);
        echo = 1'b0;
        wait_idle("stuck", -1);
        tick(2);

        // 6: reset 5 us into the echo, then a fresh 20 us measurement.
        pulse_start();
        wait_trigger_fall("rst", 500);
        tick(10);
        echo = 1'b1;
        tick(252);
        reset = 1'b1;
        tick(1);
        check_outputs_zero("rst_mid");
        reset = 1'b0;
        echo  = 1'b0;
        tick(5);
        pulse_start();
        wait_trigger_fall("rst_after", 500);
        tick(30);
        echo = 1'b1;
        tick(1000);
        echo = 1'b0;
        expect_result("rst_after", 3, 20, 1'b0);
        wait_idle("rst_after", -1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
